// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one Han-Carlson prefix adder among NREQ requesters,
// 2-stage pipeline (S1 operands, S2 response). Optional counters via ADDER_RR_PERF_EN.

module han_carlson #(
    parameter int N = 32,
    parameter int K = 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int M    = N + 1;
    localparam int S    = 1 << K;
    localparam int LOGM = $clog2(M) + 1;

    logic [M-1:0] g0;
    logic [M-1:0] p0;
    logic [M-1:0] gg;
    logic [M-1:0] pp;

    // Position 0 carries cin as a generate; carries c[j] are group generates G[j:0].
    always_comb begin
        g0 = {a & b, cin};
        p0 = {a ^ b, 1'b0};
        gg = g0;
        pp = p0;
        // Brent-Kung up-sweep builds blocks of S bits on the spine nodes.
        for (int l = 1; l <= K; l++) begin
            for (int i = M - 1; i >= 0; i--) begin
                if ((((i + 1) % (1 << l)) == 0) && (i >= (1 << (l - 1)))) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << (l - 1))]);
                    pp[i] = pp[i] & pp[i - (1 << (l - 1))];
                end
            end
        end
        // Kogge-Stone over the spine; descending order keeps reads on the previous level.
        for (int s = 0; s < LOGM; s++) begin
            for (int i = M - 1; i >= 0; i--) begin
                if (((S << s) < M) && (i >= (S << s)) && (((i + 1) % S) == 0)) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (S << s)]);
                    pp[i] = pp[i] & pp[i - (S << s)];
                end
            end
        end
        // Brent-Kung down-sweep fills the off-spine positions.
        for (int l = K; l >= 1; l--) begin
            for (int i = M - 1; i >= 0; i--) begin
                if ((((i + 1) % (1 << l)) == (1 << (l - 1))) && (i >= (1 << (l - 1)))) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << (l - 1))]);
                    pp[i] = pp[i] & pp[i - (1 << (l - 1))];
                end
            end
        end
        sum  = p0[N:1] ^ gg[N-1:0];
        cout = gg[N];
    end
endmodule

module adder_rr_scheduler #(
    parameter  int N    = 32,
    parameter  int K    = 1,
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_sum,
    output logic              rsp_cout
`ifdef ADDER_RR_PERF_EN
    ,
    output logic [31:0]       perf_ops,
    output logic [31:0]       perf_stall
`endif
);
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           s1_v_q, s1_v_d;
    logic [N-1:0]   s1_a_q, s1_a_d;
    logic [N-1:0]   s1_b_q, s1_b_d;
    logic           s1_cin_q, s1_cin_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [N-1:0]   rsp_sum_q, rsp_sum_d;
    logic           rsp_cout_q, rsp_cout_d;

    logic [IDW-1:0] gnt_id;
    logic           gnt_any;
    logic           adv1, adv2, accept;
    logic [N-1:0]   add_sum;
    logic           add_cout;

    // Scan from rr_ptr upward with wrap; iterating far-to-near lets the nearest valid win.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
    end

    assign adv2 = !rsp_valid_q || rsp_ready;
    assign adv1 = !s1_v_q || adv2;

    always_comb begin
        req_ready = '0;
        if (!rst && adv1 && gnt_any) req_ready[gnt_id] = 1'b1;
    end

    assign accept = |(req_valid & req_ready);

    han_carlson #(.N(N), .K(K)) u_adder (
        .a    (s1_a_q),
        .b    (s1_b_q),
        .cin  (s1_cin_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        s1_v_d      = s1_v_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_cin_d    = s1_cin_q;
        s1_id_d     = s1_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        if (adv1) begin
            s1_v_d = accept;
            if (accept) begin
                s1_a_d   = req_a[int'(gnt_id)*N +: N];
                s1_b_d   = req_b[int'(gnt_id)*N +: N];
                s1_cin_d = req_cin[gnt_id];
                s1_id_d  = gnt_id;
                rr_ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            end
        end
        // S2 holds its contents while stalled; it only reloads when S1 carries an op.
        if (adv2) begin
            rsp_valid_d = s1_v_q;
            if (s1_v_q) begin
                rsp_id_d   = s1_id_q;
                rsp_sum_d  = add_sum;
                rsp_cout_d = add_cout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            s1_v_q      <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_cin_q    <= 1'b0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            s1_v_q      <= s1_v_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_cin_q    <= s1_cin_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

`ifdef ADDER_RR_PERF_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_ops_d   = perf_ops_q + {31'd0, accept};
        perf_stall_d = perf_stall_q + {31'd0, rsp_valid_q & !rsp_ready};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: directed steps then random traffic, checked against a
// queue-based reference model; a second instance (N=13, K=2, NREQ=3) runs alongside.

module tb_adder_rr_scheduler;
    localparam int N     = 32;
    localparam int NREQ  = 4;
    localparam int N2    = 13;
    localparam int NREQ2 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_valid, req_ready, req_cin;
    logic [NREQ*N-1:0] req_a, req_b;
    logic              rsp_valid, rsp_ready, rsp_cout;
    logic [1:0]        rsp_id;
    logic [N-1:0]      rsp_sum;

    logic [NREQ2-1:0]    v2, rdy2, cin2;
    logic [NREQ2*N2-1:0] a2, b2;
    logic                rsp_valid2, rsp_cout2;
    logic                rsp_ready2 = 1'b1;
    logic [1:0]          rsp_id2;
    logic [N2-1:0]       rsp_sum2;

`ifdef ADDER_RR_PERF_EN
    logic [31:0] perf_ops, perf_stall, perf_ops2, perf_stall2;
`endif

    adder_rr_scheduler #(.N(N), .K(1), .NREQ(NREQ)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
`ifdef ADDER_RR_PERF_EN
        , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
    );

    adder_rr_scheduler #(.N(N2), .K(2), .NREQ(NREQ2)) u_dut13 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2),
        .req_a(a2), .req_b(b2), .req_cin(cin2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_id(rsp_id2),
        .rsp_sum(rsp_sum2), .rsp_cout(rsp_cout2)
`ifdef ADDER_RR_PERF_EN
        , .perf_ops(perf_ops2), .perf_stall(perf_stall2)
`endif
    );

    typedef struct {
        logic [1:0]  id;
        logic [31:0] sum;
        logic        cout;
        bit          at_out;
    } ent_t;

    ent_t        m_q[$];
    logic [16:0] q2[$];
    int m_ptr, m_ptr2, last_g, last_g2;
    int n_acc, n_stall, n_acc2;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [7:0] v, input int ptr, input int n);
        for (int k = 0; k < n; k++) begin
            int i;
            i = (ptr + k) % n;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Check outputs at the falling edge, then advance the model to the next rising edge.
    task automatic cycle();
        bit head_out, s1_busy, adv2, head2;
        int g, g2;
        logic [32:0] full;
        logic [13:0] full2;
        logic [16:0] t;
        ent_t e;
        @(negedge clk);
        head_out = (m_q.size() > 0) && m_q[0].at_out;
        s1_busy = 1'b0;
        foreach (m_q[j]) if (!m_q[j].at_out) s1_busy = 1'b1;
        adv2 = !head_out || rsp_ready;
        g = (rst || (s1_busy && !adv2)) ? -1 : rr_pick({4'b0, req_valid}, m_ptr, NREQ);
        chk("req_ready", {60'd0, req_ready}, (g < 0) ? 64'd0 : (64'd1 << g));
        chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, head_out});
        if (head_out) begin
            chk("rsp_id", {62'd0, rsp_id}, {62'd0, m_q[0].id});
            chk("rsp_sum", {32'd0, rsp_sum}, {32'd0, m_q[0].sum});
            chk("rsp_cout", {63'd0, rsp_cout}, {63'd0, m_q[0].cout});
        end
        head2 = (q2.size() > 0) && q2[0][16];
        g2 = rst ? -1 : rr_pick({5'b0, v2}, m_ptr2, NREQ2);
        chk("b_req_ready", {61'd0, rdy2}, (g2 < 0) ? 64'd0 : (64'd1 << g2));
        chk("b_rsp_valid", {63'd0, rsp_valid2}, {63'd0, head2});
        if (head2) chk("b_rsp", {48'd0, rsp_id2, rsp_cout2, rsp_sum2}, {48'd0, q2[0][15:0]});
        last_g  = g;
        last_g2 = g2;
        if (rst) begin
            m_q.delete();
            q2.delete();
            m_ptr = 0; m_ptr2 = 0; n_acc = 0; n_stall = 0; n_acc2 = 0;
        end else begin
            if (head_out && !rsp_ready) n_stall++;
            if (head_out && rsp_ready) void'(m_q.pop_front());
            if (adv2) begin
                for (int j = 0; j < m_q.size(); j++) begin
                    if (!m_q[j].at_out) begin
                        m_q[j].at_out = 1'b1;
                        break;
                    end
                end
            end
            if (g >= 0) begin
                full = {1'b0, req_a[g*N +: N]} + {1'b0, req_b[g*N +: N]} + {32'd0, req_cin[g]};
                e.id = 2'(g); e.sum = full[31:0]; e.cout = full[32]; e.at_out = 1'b0;
                m_q.push_back(e);
                m_ptr = (g + 1) % NREQ;
                n_acc++;
            end
            if (head2) void'(q2.pop_front());
            if (q2.size() > 0) begin
                t = q2[0];
                t[16] = 1'b1;
                q2[0] = t;
            end
            if (g2 >= 0) begin
                full2 = {1'b0, a2[g2*N2 +: N2]} + {1'b0, b2[g2*N2 +: N2]} + {13'd0, cin2[g2]};
                q2.push_back({1'b0, 2'(g2), full2[13], full2[12:0]});
                m_ptr2 = (g2 + 1) % NREQ2;
                n_acc2++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
        req_valid[i] = 1'b1;
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
        req_cin[i] = c;
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0: return 32'hFFFF_FFFF;
            1: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
        v2 = '0; a2 = '0; b2 = '0; cin2 = '0;
        m_ptr = 0; m_ptr2 = 0; n_acc = 0; n_stall = 0; n_acc2 = 0;
        @(posedge clk);
        #1;

        // Reset held two cycles, even with a request pending.
        set_req(1, 32'h5, 32'h6, 1'b0);
        cycle();
        cycle();
        chk("rst_rsp_id", {62'd0, rsp_id}, 64'd0);
        chk("rst_rsp_sum", {32'd0, rsp_sum}, 64'd0);
        chk("rst_rsp_cout", {63'd0, rsp_cout}, 64'd0);
        req_valid = '0;

        // Overflowing add from requester 0.
        rst = 1'b0;
        set_req(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        #1 chk("t1_ready", {60'd0, req_ready}, 64'h1);
        cycle();
        req_valid = '0;
        cycle();
        chk("t1_valid", {63'd0, rsp_valid}, 64'd1);
        chk("t1_sum", {32'd0, rsp_sum}, 64'd0);
        chk("t1_cout", {63'd0, rsp_cout}, 64'd1);
        chk("t1_id", {62'd0, rsp_id}, 64'd0);

        // All requesters valid: grants rotate 1,2,3,0,... after requester 0 was served.
        for (int i = 0; i < NREQ; i++) set_req(i, rnd32(), rnd32(), 1'($urandom_range(0, 1)));
        for (int k = 0; k < 8; k++) begin
            #1 chk("t2_order", {60'd0, req_ready}, 64'd1 << ((1 + k) % NREQ));
            cycle();
            set_req(last_g, rnd32(), rnd32(), 1'($urandom_range(0, 1)));
        end

        // Output stall with a full pipe, then release.
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (last_g >= 0) set_req(last_g, rnd32(), rnd32(), 1'($urandom_range(0, 1)));
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (last_g >= 0) set_req(last_g, rnd32(), rnd32(), 1'($urandom_range(0, 1)));
        end
        req_valid = '0;
        for (int k = 0; k < 3; k++) cycle();

        // Requester 2 alone, then 1 and 3 contend with the pointer at 3.
        set_req(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
        #1 chk("t4_ready", {60'd0, req_ready}, 64'h4);
        cycle();
        req_valid = '0;
        cycle();
        chk("t4_sum", {32'd0, rsp_sum}, 64'h8000_0001);
        chk("t4_cout", {63'd0, rsp_cout}, 64'd0);
        chk("t4_id", {62'd0, rsp_id}, 64'd2);
        set_req(1, 32'h10, 32'h20, 1'b0);
        set_req(3, 32'h30, 32'h40, 1'b1);
        #1 chk("t4_rr", {60'd0, req_ready}, 64'h8);
        cycle();
        req_valid[3] = 1'b0;
        cycle();
        req_valid = '0;
        for (int k = 0; k < 3; k++) cycle();

        // Reset with two ops in flight.
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, rnd32(), rnd32(), 1'b1);
        for (int k = 0; k < 2; k++) begin
            cycle();
            if (last_g >= 0) req_valid[last_g] = 1'b0;
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        chk("t5_valid", {63'd0, rsp_valid}, 64'd0);
        set_req(0, 32'h1, 32'h2, 1'b0);
        set_req(3, 32'h3, 32'h4, 1'b0);
        #1 chk("t5_ptr0", {60'd0, req_ready}, 64'h1);
        cycle();
        req_valid = '0;
        for (int k = 0; k < 3; k++) cycle();

        // Random traffic on both instances; requesters hold until accepted.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i] && $urandom_range(0, 99) < 60)
                    set_req(i, rnd32(), rnd32(), 1'($urandom_range(0, 1)));
            for (int i = 0; i < NREQ2; i++) begin
                if (!v2[i] && $urandom_range(0, 99) < 50) begin
                    v2[i] = 1'b1;
                    a2[i*N2 +: N2] = 13'($urandom);
                    b2[i*N2 +: N2] = ($urandom_range(0, 3) == 0) ? 13'h1FFF : 13'($urandom);
                    cin2[i] = 1'($urandom_range(0, 1));
                end
            end
            rsp_ready = ($urandom_range(0, 99) < 70);
            cycle();
            if (last_g >= 0) req_valid[last_g] = 1'b0;
            if (last_g2 >= 0) v2[last_g2] = 1'b0;
        end
        req_valid = '0;
        v2 = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle();

`ifdef ADDER_RR_PERF_EN
        chk("perf_ops", {32'd0, perf_ops}, 64'(n_acc));
        chk("perf_stall", {32'd0, perf_stall}, 64'(n_stall));
        chk("b_perf_ops", {32'd0, perf_ops2}, 64'(n_acc2));
        chk("b_perf_stall", {32'd0, perf_stall2}, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
